// File: rtl/thermostat_ctrl.sv
// thermostat_ctrl: periodic sensor sampler with 4-sample running average and hysteretic heat/cool control
module thermostat_ctrl #(
    parameter int SAMPLE_DIV  = 100000000,
    parameter int HYST        = 2,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic [7:0]  i_setpoint,
    output logic        o_rd_req,
    input  logic        i_rd_ack,
    input  logic [12:0] i_rd_data,
    output logic [12:0] o_temp_avg,
    output logic        o_sample_valid,
    output logic [1:0]  o_mode,
    output logic        o_heat_on,
    output logic        o_cool_on,
    output logic        o_sensor_fault
);
    localparam int CMAX = SAMPLE_DIV > ACK_TIMEOUT ? SAMPLE_DIV : ACK_TIMEOUT;
    localparam int CW = CMAX > 2 ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] TICK_END = CW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] ACK_END = CW'(ACK_TIMEOUT - 1);
    localparam logic [1:0] S_WAIT = 2'd0, S_REQ = 2'd1, S_UPD = 2'd2;
    localparam logic [1:0] M_IDLE = 2'd0, M_HEAT = 2'd1, M_COOL = 2'd2;

    logic [1:0]         r_state, w_state_nx;
    logic [CW-1:0]      r_cnt, w_cnt_nx;
    logic               w_accept, w_timeout;
    logic [12:0]        r_buf [4];
    logic [1:0]         r_wp;
    logic               r_filled;
    logic [14:0]        r_sum, w_sum_nx;
    logic [12:0]        r_avg;
    logic               r_valid, r_fault;
    logic [1:0]         r_mode, w_mode_nx;
    logic               r_heat, r_cool;
    logic signed [13:0] w_avg, w_sp, w_lo, w_hi;

    assign w_accept  = i_enable && r_state == S_REQ && i_rd_ack;
    assign w_timeout = i_enable && r_state == S_REQ && !i_rd_ack && r_cnt == ACK_END;

    // One counter serves as the sample-period tick in WAIT and the ack timer in REQ
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = S_WAIT;
        w_cnt_nx   = '0;
        if (i_enable && r_state == S_WAIT) begin
            w_state_nx = r_cnt == TICK_END ? S_REQ : S_WAIT;
            w_cnt_nx   = r_cnt == TICK_END ? '0 : r_cnt + 1'b1;
        end else if (i_enable && r_state == S_REQ) begin
            w_state_nx = w_accept ? S_UPD : w_timeout ? S_WAIT : S_REQ;
            w_cnt_nx   = (w_accept || w_timeout) ? '0 : r_cnt + 1'b1;
        end
    end

    always_comb o_rd_req = r_state == S_REQ;

    // An empty buffer is flooded with the first sample so the average starts at that value
    assign w_sum_nx = r_filled ? r_sum - 15'(r_buf[r_wp]) + 15'(i_rd_data) : {i_rd_data, 2'b00};

    always_ff @(posedge i_clk)
        if (!i_reset && w_accept)
            for (int i = 0; i < 4; i++)
                if (!r_filled || r_wp == 2'(i)) r_buf[i] <= i_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_filled <= 1'b0;
            r_wp     <= '0;
            r_sum    <= '0;
            r_avg    <= '0;
            r_valid  <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_valid <= w_accept;
            r_fault <= w_timeout ? 1'b1 : w_accept ? 1'b0 : r_fault;
            if (w_accept) begin
                r_filled <= 1'b1;
                r_wp     <= r_wp + 1'b1;
                r_sum    <= w_sum_nx;
                r_avg    <= w_sum_nx[14:2];
            end
        end
    end

    assign o_temp_avg     = r_avg;
    assign o_sample_valid = r_valid;
    assign o_sensor_fault = r_fault;

    // Signed 14-bit thresholds keep setpoint-HYST from wrapping when setpoint < HYST
    assign w_avg = {1'b0, r_avg};
    assign w_sp  = {6'b0, i_setpoint};
    assign w_lo  = w_sp - 14'(HYST);
    assign w_hi  = w_sp + 14'(HYST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mode <= M_IDLE;
            r_heat <= 1'b0;
            r_cool <= 1'b0;
        end else begin
            r_mode <= w_mode_nx;
            r_heat <= w_mode_nx == M_HEAT;
            r_cool <= w_mode_nx == M_COOL;
        end
    end

    always_comb begin
        w_mode_nx = r_mode;
        if (!i_enable || w_timeout)
            w_mode_nx = M_IDLE;
        else if (r_valid)
            w_mode_nx = r_mode == M_IDLE ? (w_avg < w_lo ? M_HEAT : w_avg > w_hi ? M_COOL : M_IDLE) :
                        r_mode == M_HEAT ? (w_avg >= w_sp ? M_IDLE : M_HEAT) :
                        (r_mode == M_COOL && w_avg > w_sp) ? M_COOL : M_IDLE;
    end

    always_comb begin
        o_mode    = r_mode;
        o_heat_on = r_heat;
        o_cool_on = r_cool;
    end
endmodule

// File: tb/tb_thermostat_ctrl.sv
// tb_thermostat_ctrl: randomized self-checking bench against a queue-based average and rule-based mode model
module tb_thermostat_ctrl;
    localparam int SD = 10;
    localparam int HY = 2;
    localparam int AT = 16;

    logic        clk = 0;
    logic        reset = 1;
    logic        enable = 0;
    logic [7:0]  setpoint = 72;
    logic        rd_ack = 0;
    logic [12:0] rd_data = 0;
    logic        rd_req, sample_valid, heat_on, cool_on, sensor_fault;
    logic [12:0] temp_avg;
    logic [1:0]  mode;

    int n_tests = 0;
    int n_fail = 0;
    int mq[$];
    int m_avg = 0;
    int m_mode = 0;

    thermostat_ctrl #(.SAMPLE_DIV(SD), .HYST(HY), .ACK_TIMEOUT(AT)) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_setpoint(setpoint),
        .o_rd_req(rd_req), .i_rd_ack(rd_ack), .i_rd_data(rd_data),
        .o_temp_avg(temp_avg), .o_sample_valid(sample_valid), .o_mode(mode),
        .o_heat_on(heat_on), .o_cool_on(cool_on), .o_sensor_fault(sensor_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic model_sample(input int d, input int sp);
        int s = 0;
        if (mq.size() == 0) repeat (4) mq.push_back(d);
        else begin
            void'(mq.pop_front());
            mq.push_back(d);
        end
        foreach (mq[i]) s += mq[i];
        m_avg = s / 4;
        if (m_mode == 0) m_mode = (m_avg < sp - HY) ? 1 : (m_avg > sp + HY) ? 2 : 0;
        else if (m_mode == 1) m_mode = (m_avg >= sp) ? 0 : 1;
        else m_mode = (m_avg <= sp) ? 0 : 2;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        mq.delete();
        m_avg = 0;
        m_mode = 0;
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (rd_req) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_rd_req: rd_req=%0b after 60 cycles, required 1", rd_req);
        end
    endtask

    // Leaves the caller at the negedge one cycle after the ack was sampled
    task automatic do_sample(input int d, output bit ok);
        wait_req(ok);
        if (!ok) return;
        rd_ack = 1;
        rd_data = 13'(d);
        model_sample(d, int'(setpoint));
        @(negedge clk);
        rd_ack = 0;
        rd_data = 13'($urandom);
    endtask

    task automatic test_reset();
        reset = 1;
        enable = 1;
        setpoint = 72;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({rd_req, temp_avg, sample_valid, mode, heat_on, cool_on, sensor_fault} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_state: req=%0b avg=%0d sv=%0b mode=%0d heat=%0b cool=%0b fault=%0b required all 0",
                     rd_req, temp_avg, sample_valid, mode, heat_on, cool_on, sensor_fault);
        end
        reset = 0;
        mq.delete();
        m_avg = 0;
        m_mode = 0;
    endtask

    task automatic test_first_sample();
        int n = 0;
        bit ok;
        while (!rd_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n != SD) begin
            n_fail++;
            $display("FAIL first_req_latency: %0d cycles, required %0d", n, SD);
        end
        do_sample(70, ok);
        n_tests++;
        if (temp_avg !== 13'd70 || sample_valid !== 1'b1 || rd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL first_sample: avg=%0d sv=%0b req=%0b required 70/1/0", temp_avg, sample_valid, rd_req);
        end
        @(negedge clk);
        n_tests++;
        if (sample_valid !== 1'b0 || mode !== 2'(m_mode)) begin
            n_fail++;
            $display("FAIL first_sample_after: sv=%0b mode=%0d required 0/%0d", sample_valid, mode, m_mode);
        end
    endtask

    task automatic test_heat_hyst();
        int seq[10] = '{68, 68, 68, 68, 80, 80, 80, 80, 80, 80};
        bit ok;
        setpoint = 72;
        reset_dut();
        foreach (seq[k]) begin
            do_sample(seq[k], ok);
            n_tests++;
            if (temp_avg !== 13'(m_avg) || sample_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hyst_avg[%0d]: avg=%0d sv=%0b required %0d/1", k, temp_avg, sample_valid, m_avg);
            end
            @(negedge clk);
            n_tests++;
            if (mode !== 2'(m_mode) || heat_on !== (m_mode == 1) || cool_on !== (m_mode == 2)) begin
                n_fail++;
                $display("FAIL hyst_mode[%0d]: mode=%0d heat=%0b cool=%0b required mode %0d", k, mode, heat_on, cool_on, m_mode);
            end
            if (k == 0) begin
                n_tests++;
                if (mode !== 2'b01) begin
                    n_fail++;
                    $display("FAIL hyst_first_heat: mode=%0d required 1", mode);
                end
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int d;
        for (int k = 0; k < 25; k++) begin
            setpoint = 8'($urandom_range(60, 90));
            d = (k % 6 == 5) ? int'($urandom_range(0, 8191)) : int'($urandom_range(40, 110));
            do_sample(d, ok);
            n_tests++;
            if (temp_avg !== 13'(m_avg) || sample_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_avg[%0d]: avg=%0d sv=%0b required %0d/1", k, temp_avg, sample_valid, m_avg);
            end
            @(negedge clk);
            n_tests++;
            if (mode !== 2'(m_mode) || heat_on !== (m_mode == 1) || cool_on !== (m_mode == 2)) begin
                n_fail++;
                $display("FAIL rand_mode[%0d]: mode=%0d heat=%0b cool=%0b required mode %0d", k, mode, heat_on, cool_on, m_mode);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int n = 0;
        setpoint = 72;
        reset_dut();
        do_sample(60, ok);
        @(negedge clk);
        n_tests++;
        if (mode !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_pre_heat: mode=%0d required 1", mode);
        end
        wait_req(ok);
        while (rd_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        m_mode = 0;
        n_tests++;
        if (n != AT) begin
            n_fail++;
            $display("FAIL timeout_len: rd_req high %0d cycles, required %0d", n, AT);
        end
        n_tests++;
        if (sensor_fault !== 1'b1 || mode !== 2'b00 || rd_req !== 1'b0 || heat_on !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state: fault=%0b mode=%0d req=%0b heat=%0b required 1/0/0/0", sensor_fault, mode, rd_req, heat_on);
        end
        do_sample(60, ok);
        n_tests++;
        if (sensor_fault !== 1'b0 || temp_avg !== 13'(m_avg)) begin
            n_fail++;
            $display("FAIL timeout_clear: fault=%0b avg=%0d required 0/%0d", sensor_fault, temp_avg, m_avg);
        end
        @(negedge clk);
        n_tests++;
        if (mode !== 2'(m_mode)) begin
            n_fail++;
            $display("FAIL timeout_recover_mode: mode=%0d required %0d", mode, m_mode);
        end
    endtask

    task automatic test_underflow();
        bit ok;
        setpoint = 1;
        reset_dut();
        for (int k = 0; k < 2; k++) begin
            do_sample(0, ok);
            n_tests++;
            if (temp_avg !== 13'd0 || sample_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL underflow_avg[%0d]: avg=%0d sv=%0b required 0/1", k, temp_avg, sample_valid);
            end
            @(negedge clk);
            n_tests++;
            if (mode !== 2'b00 || mode !== 2'(m_mode)) begin
                n_fail++;
                $display("FAIL underflow_mode[%0d]: mode=%0d required 0", k, mode);
            end
        end
    endtask

    task automatic test_enable_drop();
        bit ok;
        bit seen = 0;
        int n = 0;
        setpoint = 72;
        reset_dut();
        do_sample(60, ok);
        wait_req(ok);
        enable = 0;
        m_mode = 0;
        @(negedge clk);
        n_tests++;
        if (rd_req !== 1'b0 || mode !== 2'b00 || heat_on !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop: req=%0b mode=%0d heat=%0b required 0/0/0", rd_req, mode, heat_on);
        end
        rd_ack = 1;
        rd_data = 13'd99;
        @(negedge clk);
        rd_ack = 0;
        n_tests++;
        if (temp_avg !== 13'(m_avg) || sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_ack: avg=%0d sv=%0b required %0d/0", temp_avg, sample_valid, m_avg);
        end
        repeat (20) begin
            @(negedge clk);
            seen |= rd_req;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL disabled_idle: rd_req seen=%0b required 0", seen);
        end
        enable = 1;
        while (!rd_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n != SD) begin
            n_fail++;
            $display("FAIL reenable_latency: %0d cycles, required %0d", n, SD);
        end
        do_sample(60, ok);
        n_tests++;
        if (temp_avg !== 13'(m_avg)) begin
            n_fail++;
            $display("FAIL reenable_avg: avg=%0d required %0d", temp_avg, m_avg);
        end
        @(negedge clk);
        n_tests++;
        if (mode !== 2'(m_mode)) begin
            n_fail++;
            $display("FAIL reenable_mode: mode=%0d required %0d", mode, m_mode);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_req(ok);
        n_tests++;
        if (mode !== 2'b01 || rd_req !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: mode=%0d req=%0b required 1/1", mode, rd_req);
        end
        reset = 1;
        rd_ack = 1;
        rd_data = 13'd5;
        @(negedge clk);
        n_tests++;
        if ({rd_req, temp_avg, sample_valid, mode, heat_on, cool_on, sensor_fault} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_mid: req=%0b avg=%0d sv=%0b mode=%0d heat=%0b cool=%0b fault=%0b required all 0",
                     rd_req, temp_avg, sample_valid, mode, heat_on, cool_on, sensor_fault);
        end
        rd_ack = 0;
        reset = 0;
        mq.delete();
        m_avg = 0;
        m_mode = 0;
        do_sample(80, ok);
        n_tests++;
        if (temp_avg !== 13'(m_avg) || temp_avg !== 13'd80) begin
            n_fail++;
            $display("FAIL reset_mid_refill: avg=%0d required 80", temp_avg);
        end
        @(negedge clk);
        n_tests++;
        if (mode !== 2'(m_mode) || cool_on !== (m_mode == 2)) begin
            n_fail++;
            $display("FAIL reset_mid_mode: mode=%0d cool=%0b required mode %0d", mode, cool_on, m_mode);
        end
    endtask

    initial begin
        test_reset();
        test_first_sample();
        test_heat_hyst();
        test_random();
        test_timeout();
        test_underflow();
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/thermostat_ctrl.md
THERMOSTAT_CTRL -- requirements
Module: thermostat_ctrl

Interface
REQ-001 Parameter SAMPLE_DIV, default 100000000, SHALL set the number of clk cycles between sample requests.
REQ-002 Parameter HYST, default 2, SHALL set the hysteresis band in degrees F.
REQ-003 Parameter ACK_TIMEOUT, default 1024, SHALL set the maximum number of cycles to wait for rd_ack.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-006 enable  in  1  SHALL gate sampling and control; low = halt.
REQ-007 setpoint  in  8  SHALL be the target temperature, unsigned degrees F.
REQ-008 rd_req  out  1  SHALL be the sample request to the temperature reader.
REQ-009 rd_ack  in  1  SHALL be the one-cycle reader-done strobe, qualifying rd_data.
REQ-010 rd_data  in  13  SHALL be the sensor temperature, unsigned degrees F.
REQ-011 temp_avg  out  13  SHALL be the 4-sample running average.
REQ-012 sample_valid  out  1  SHALL pulse for one cycle when temp_avg updates.
REQ-013 mode  out  2  SHALL report the control state: 00 IDLE, 01 HEAT, 10 COOL.
REQ-014 heat_on / cool_on  out  1 each  SHALL equal mode==HEAT / mode==COOL, registered.
REQ-015 sensor_fault  out  1  SHALL flag a reader timeout.

Function
REQ-016 Sequencer FSM SHALL have states WAIT, REQ, UPDATE; reset state WAIT.
REQ-017 WAIT: the tick counter SHALL increment; at SAMPLE_DIV-1 it SHALL clear and the FSM SHALL enter REQ.
REQ-018 REQ: rd_req SHALL be held high until rd_ack is sampled high, then deasserted the next cycle; the FSM SHALL enter UPDATE.
REQ-019 rd_ack outside REQ SHALL be ignored, with no state or output change.
REQ-020 Timeout: if rd_ack is absent for ACK_TIMEOUT cycles in REQ, rd_req SHALL drop, sensor_fault SHALL set, mode SHALL be forced to IDLE, and the FSM SHALL return to WAIT.
REQ-021 sensor_fault SHALL clear on the next accepted rd_ack.
REQ-022 Averaging: a 4-entry sample buffer and a 15-bit sum; temp_avg = sum >> 2 (truncate).
REQ-023 The first accepted sample after reset SHALL fill all 4 entries, so temp_avg equals that sample.
REQ-024 Latency: rd_ack in cycle N SHALL give temp_avg and sample_valid in N+1, and the mode decision in N+2.
REQ-025 The mode FSM SHALL evaluate only on sample_valid, using 14-bit signed compares so setpoint<HYST does not wrap.
REQ-026 IDLE->HEAT if temp_avg < setpoint-HYST; IDLE->COOL if temp_avg > setpoint+HYST; otherwise stay.
REQ-027 HEAT->IDLE if temp_avg >= setpoint; COOL->IDLE if temp_avg <= setpoint.
REQ-028 HEAT<->COOL direct transitions SHALL NOT occur; at most one mode transition per sample.
REQ-029 enable low SHALL, within one cycle, force mode IDLE, drop rd_req, hold the tick counter at 0, and put the FSM in WAIT; the averaging buffer SHALL be retained.
REQ-030 If enable falls while in REQ, a later rd_ack SHALL be ignored.
REQ-031 A setpoint change SHALL take effect at the next sample_valid only.

Reset
REQ-032 Reset SHALL give: rd_req=0, temp_avg=0, sample_valid=0, mode=IDLE, heat_on=0, cool_on=0, sensor_fault=0, tick counter 0, buffer marked empty.
REQ-033 Reset SHALL take priority over all inputs, including when asserted mid-handshake.

Verification
REQ-034 SAMPLE_DIV=10, enable=1 -> rd_req rises 10 cycles after reset release; ack with rd_data=70 -> temp_avg=70, sample_valid in the next cycle.
REQ-035 setpoint=72, HYST=2, samples 68,68,68,68 -> mode=HEAT after the first sample; samples of 80 -> the average rises and mode returns to IDLE at the first avg>=72, with no COOL until a later avg>74.
REQ-036 No rd_ack for ACK_TIMEOUT cycles -> rd_req=0, sensor_fault=1, mode=IDLE; the next request acked -> sensor_fault=0.
REQ-037 setpoint=1, HYST=2, rd_data=0 -> mode stays IDLE (no underflow to HEAT).
REQ-038 enable dropped during REQ, then a stray rd_ack -> temp_avg unchanged, no sample_valid, mode=IDLE.
REQ-039 Reset pulsed while in HEAT with rd_req high -> all outputs at REQ-032 values the next cycle.
